uart_ser_tx: RTL and testbench

UART_SER_TX -- requirements
Module: uart_ser_tx

---
 rtl/uart_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_ser_tx.sv | 175 +++++++++++++++++
 tb/tb_uart_ser_tx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART serial transmitter.
package uart_pkg;

  // Transmitter FSM states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_state_t;

  // Parity parameter encodings.
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Elaboration-time legality check for the transmitter parameter set.
  function automatic bit params_ok(input int data_bits, input int fifo_depth,
                                   input int clks_per_bit, input int parity,
                                   input int stop_bits);
    return (data_bits >= 5) && (data_bits <= 9) &&
           (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0) &&
           (clks_per_bit >= 2) &&
           (parity >= PARITY_NONE) && (parity <= PARITY_EVEN) &&
           ((stop_bits == 1) || (stop_bits == 2));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output and occupancy count.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       data,
  output logic [WIDTH-1:0]       q,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LEVEL_FULL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign q       = mem[rd_ptr];

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  // Pointers wrap modulo DEPTH; level tracks accepted pushes minus pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_ser_tx.sv
// Buffered UART transmitter: FIFO front end, baud-timed frame serialiser.
module uart_ser_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        w,
  input  logic [DATA_BITS-1:0]        p,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        busy,
  output logic                        Rx
);

  if (!params_ok(DATA_BITS, FIFO_DEPTH, CLKS_PER_BIT, PARITY, STOP_BITS)) begin : g_param_check
    $error("uart_ser_tx: illegal parameter set");
  end

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          PAR_ODD   = (PARITY == PARITY_ODD);
  localparam bit            HAS_PAR   = (PARITY != PARITY_NONE);

  logic [1:0]           rst_sync;
  logic                 rst_i;
  uart_state_t          state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 pend_q;
  logic                 pop;
  logic                 tick;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head;

  // Reset asserts asynchronously and releases after two clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i = rst_sync[1];

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_i),
    .push  (w),
    .pop   (pop),
    .data  (p),
    .q     (head),
    .level (level),
    .full  (full),
    .empty (fifo_empty)
  );

  assign tick = (baud_q == BAUD_LAST);
  assign busy = (state_q != IDLE);

  // Dropped-write indicator, one cycle after the rejected strobe.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) overflow <= 1'b0;
    else        overflow <= w & full;
  end

  // FSM, baud counter, shifter and parity registers.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      pend_q  <= (level != '0);
    end
  end

  // Next-state logic; IDLE reacts to the registered occupancy flag so the
  // first pop lands two edges after the write, while back-to-back frames
  // chain straight from the last stop bit using the live FIFO state.
  always_comb begin
    state_d = state_q;
    baud_d  = tick ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    stop_d  = stop_q;
    sh_d    = sh_q;
    par_d   = par_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (pend_q && !fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
          sh_d    = head;
          par_d   = (^head) ^ PAR_ODD;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          sh_d = sh_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = HAS_PAR ? PAR : STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (tick) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_q == STOP_LAST) begin
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = START;
              sh_d    = head;
              par_d   = (^head) ^ PAR_ODD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serial line value for the current state.
  always_comb begin
    Rx = 1'b1;
    case (state_q)
      START:   Rx = 1'b0;
      DATA:    Rx = sh_q[0];
      PAR:     Rx = par_q;
      default: Rx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_ser_tx.sv
// Scoreboard bench: stimulus queues expected frames, monitors decode Rx.
module tb_uart_ser_tx;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: even parity, one stop bit, 4-entry buffer.
  logic       rst_a, w_a, full_a, ovf_a, busy_a, rx_a;
  logic [7:0] p_a;
  logic [2:0] level_a;
  // DUT B: odd parity, two stop bits, 16-entry buffer.
  logic       rst_b, w_b, full_b, ovf_b, busy_b, rx_b;
  logic [7:0] p_b;
  logic [4:0] level_b;

  uart_ser_tx #(
    .DATA_BITS(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_a), .w(w_a), .p(p_a), .full(full_a), .level(level_a),
    .overflow(ovf_a), .busy(busy_a), .Rx(rx_a)
  );

  uart_ser_tx #(
    .DATA_BITS(8), .FIFO_DEPTH(16), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_b), .w(w_b), .p(p_b), .full(full_b), .level(level_b),
    .overflow(ovf_b), .busy(busy_b), .Rx(rx_b)
  );

  // Expected frames, bit i = i-th bit on the line (bit 0 = start bit).
  logic [11:0] exp_a[$];
  logic [11:0] exp_b[$];
  int          starts_a[$];
  int          starts_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic rx_of(input int id);
    return (id == 0) ? rx_a : rx_b;
  endfunction
  function automatic logic rst_of(input int id);
    return (id == 0) ? rst_a : rst_b;
  endfunction
  function automatic logic busy_of(input int id);
    return (id == 0) ? busy_a : busy_b;
  endfunction

  task automatic flush(input int id);
    if (id == 0) exp_a.delete();
    else         exp_b.delete();
  endtask

  // Frame decoder: every cycle of every bit must hold the same level with busy high.
  task automatic monitor(input int id);
    int          nb;
    int          st;
    logic [11:0] cap;
    logic [11:0] e;
    bit          stable, busy_ok, aborted;
    nb = (id == 0) ? 11 : 12;
    forever begin
      @(negedge clk);
      if (rst_of(id) && rx_of(id) == 1'b0) begin
        st = cyc; cap = '0; stable = 1'b1; busy_ok = 1'b1; aborted = 1'b0;
        for (int i = 0; i < nb * 4; i++) begin
          if (i > 0) @(negedge clk);
          if (!rst_of(id)) begin
            aborted = 1'b1;
            break;
          end
          if (i % 4 == 0) cap[i/4] = rx_of(id);
          else if (rx_of(id) !== cap[i/4]) stable = 1'b0;
          if (busy_of(id) !== 1'b1) busy_ok = 1'b0;
        end
        if (aborted) begin
          flush(id);
        end else begin
          if (id == 0) starts_a.push_back(st);
          else         starts_b.push_back(st);
          if (((id == 0) ? exp_a.size() : exp_b.size()) == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_frame dut %0d: got frame %0h at cycle %0d, expected none", id, cap, st);
          end else begin
            e = (id == 0) ? exp_a.pop_front() : exp_b.pop_front();
            chk((id == 0) ? "frame_a" : "frame_b", {18'd0, stable, busy_ok, cap}, {18'd0, 2'b11, e});
          end
        end
      end else if (!rst_of(id)) begin
        flush(id);
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic to_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_drain(input int id, input int budget);
    int n;
    n = 0;
    while (((id == 0) ? exp_a.size() : exp_b.size()) != 0 || busy_of(id)) begin
      if (n >= budget) begin
        n_chk++;
        n_fail++;
        $display("FAIL drain_timeout dut %0d: still busy after %0d cycles, expected idle", id, n);
        return;
      end
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    int n;
    int lows;
    rst_a = 1'b1; rst_b = 1'b1;
    w_a = 1'b0; p_a = '0; w_b = 1'b0; p_b = '0;
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    #2;
    chk("rst_rx_a", rx_a, 1);
    chk("rst_level_a", level_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_full_a", full_a, 0);
    chk("rst_ovf_a", ovf_a, 0);
    chk("rst_rx_b", rx_b, 1);
    chk("rst_level_b", level_b, 0);
    chk("rst_busy_b", busy_b, 0);
    repeat (3) @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (4) @(negedge clk);

    // Even parity frame of 0xA5 and first-write latency.
    k = cyc + 1;
    w_a = 1'b1; p_a = 8'hA5; exp_a.push_back(12'h54A);
    @(negedge clk); w_a = 1'b0;
    chk("p1_level_k", level_a, 1);
    chk("p1_rx_k", rx_a, 1);
    @(negedge clk);
    chk("p1_rx_k1", rx_a, 1);
    chk("p1_busy_k1", busy_a, 0);
    @(negedge clk);
    chk("p1_rx_k2", rx_a, 0);
    chk("p1_level_k2", level_a, 0);
    n = 0;
    while (busy_a && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("p1_busy_cycles", n, 44);
    wait_drain(0, 200);

    // Odd parity, two stop bits, 0x07.
    w_b = 1'b1; p_b = 8'h07; exp_b.push_back(12'hC0E);
    @(negedge clk); w_b = 1'b0;
    @(negedge clk);
    chk("p2_rx_k1", rx_b, 1);
    @(negedge clk);
    chk("p2_rx_k2", rx_b, 0);
    n = 0;
    while (busy_b && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("p2_busy_cycles", n, 48);
    wait_drain(1, 200);

    // Three consecutive writes: back-to-back frames.
    starts_a.delete();
    k = cyc + 1;
    w_a = 1'b1; p_a = 8'h11; exp_a.push_back(12'h422);
    @(negedge clk); chk("p3_level_k", level_a, 1);
    p_a = 8'h22; exp_a.push_back(12'h444);
    @(negedge clk); chk("p3_level_k1", level_a, 2);
    p_a = 8'h33; exp_a.push_back(12'h466);
    @(negedge clk); chk("p3_level_k2", level_a, 2);
    w_a = 1'b0;
    to_cyc(k + 45); chk("p3_level_k45", level_a, 2);
    to_cyc(k + 46); chk("p3_level_k46", level_a, 1);
    to_cyc(k + 90); chk("p3_level_k90", level_a, 0);
    wait_drain(0, 300);
    chk("p3_nframes", starts_a.size(), 3);
    if (starts_a.size() == 3) begin
      chk("p3_start0", starts_a[0], k + 2);
      chk("p3_gap01", starts_a[1] - starts_a[0], 44);
      chk("p3_gap12", starts_a[2] - starts_a[1], 44);
    end

    // Fill a 4-entry buffer behind a frame in flight, then write on a pop edge.
    k = cyc + 1;
    w_a = 1'b1; p_a = 8'h01; exp_a.push_back(12'h602);
    @(negedge clk); w_a = 1'b0;
    to_cyc(k + 2); chk("p4_busy", busy_a, 1);
    w_a = 1'b1; p_a = 8'h02; exp_a.push_back(12'h604);
    @(negedge clk); p_a = 8'h03; exp_a.push_back(12'h406);
    @(negedge clk); p_a = 8'h04; exp_a.push_back(12'h608);
    @(negedge clk); p_a = 8'h05; exp_a.push_back(12'h40A);
    @(negedge clk);
    chk("p4_full_after5", full_a, 1);
    chk("p4_level_full", level_a, 4);
    p_a = 8'h06;
    @(negedge clk); w_a = 1'b0;
    chk("p4_ovf_pulse", ovf_a, 1);
    chk("p4_level_drop", level_a, 4);
    @(negedge clk);
    chk("p4_ovf_end", ovf_a, 0);
    to_cyc(k + 45);
    chk("p4_full_prepop", full_a, 1);
    w_a = 1'b1; p_a = 8'h77;
    @(negedge clk); w_a = 1'b0;
    chk("p4_level_poppush", level_a, 3);
    chk("p4_ovf_poppush", ovf_a, 1);
    chk("p4_full_poppush", full_a, 0);
    @(negedge clk);
    chk("p4_ovf_poppush_end", ovf_a, 0);
    wait_drain(0, 400);

    // Reset mid-DATA with two words queued.
    k = cyc + 1;
    w_a = 1'b1; p_a = 8'h5A; exp_a.push_back(12'h4B4);
    @(negedge clk); p_a = 8'h3C; exp_a.push_back(12'h478);
    @(negedge clk); p_a = 8'h0F; exp_a.push_back(12'h41E);
    @(negedge clk); w_a = 1'b0;
    to_cyc(k + 15);
    chk("p5_busy_pre", busy_a, 1);
    chk("p5_level_pre", level_a, 2);
    rst_a = 1'b0;
    #1;
    chk("p5_rst_rx", rx_a, 1);
    chk("p5_rst_level", level_a, 0);
    chk("p5_rst_busy", busy_a, 0);
    chk("p5_rst_full", full_a, 0);
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (rx_a !== 1'b1 || busy_a !== 1'b0) lows++;
    end
    chk("p5_quiet", lows, 0);
    w_a = 1'b1; p_a = 8'hC3; exp_a.push_back(12'h586);
    @(negedge clk); w_a = 1'b0;
    @(negedge clk); chk("p5_rx_k1", rx_a, 1);
    @(negedge clk); chk("p5_rx_k2", rx_a, 0);
    wait_drain(0, 200);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
